// File: rtl/melon_div.sv
// Iterative restoring 32-bit divider (RV32M DIV/DIVU/REM/REMU), 34-cycle latency.
// Optional build macro MELON_DIV_FAST_SPECIAL_EN: single-cycle divide-by-zero and signed overflow.
module melon_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef MELON_DIV_FAST_SPECIAL_EN
  localparam bit FAST_SPECIAL = 1'b1;
`else
  localparam bit FAST_SPECIAL = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] part_rem, dividend, divisor, orig_a;
  logic             neg_q, neg_r, div0;
  logic             a_neg, b_neg, special;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_shift, trial;

  // The dividend register doubles as the quotient: result bits enter from the right.
  always_comb begin
    a_neg     = is_signed & a[WIDTH-1];
    b_neg     = is_signed & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    special   = FAST_SPECIAL &&
                ((b == '0) || (is_signed && (a == MIN_INT) && (b == '1)));
    rem_shift = {part_rem, dividend[WIDTH-1]};
    trial     = rem_shift - {1'b0, divisor};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (start && !special) state_next = RUN;
      RUN:     if (cnt == CW'(WIDTH-1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done     <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      cnt      <= '0;
      part_rem <= '0;
      dividend <= '0;
      divisor  <= '0;
      orig_a   <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div0     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (special) begin
              done <= 1'b1;
              quot <= (b == '0) ? '1 : MIN_INT;
              rem  <= (b == '0) ? a  : '0;
            end else begin
              part_rem <= '0;
              dividend <= a_mag;
              divisor  <= b_mag;
              neg_q    <= a_neg ^ b_neg;
              neg_r    <= a_neg;
              div0     <= (b == '0);
              orig_a   <= a;
              cnt      <= '0;
            end
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (!trial[WIDTH]) begin
            part_rem <= trial[WIDTH-1:0];
            dividend <= {dividend[WIDTH-2:0], 1'b1};
          end else begin
            part_rem <= rem_shift[WIDTH-1:0];
            dividend <= {dividend[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          done <= 1'b1;
          quot <= div0 ? '1     : (neg_q ? -dividend : dividend);
          rem  <= div0 ? orig_a : (neg_r ? -part_rem : part_rem);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_melon_div.sv
// Directed + random scoreboard bench for melon_div; expected results queue at start, pop at done.
module tb_melon_div;

  logic        clk = 1'b0;
  logic        reset, start, is_signed;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] quot, rem;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  melon_div #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .is_signed(is_signed),
    .busy(busy), .done(done), .quot(quot), .rem(rem)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      $error("[TB] check %s", tag);
    end
  endtask

  function automatic bit is_special(input logic [31:0] av, bv, input logic s);
    return (bv == 32'h0) || (s && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF);
  endfunction

  function automatic int exp_latency(input logic [31:0] av, bv, input logic s);
`ifdef MELON_DIV_FAST_SPECIAL_EN
    return is_special(av, bv, s) ? 1 : 34;
`else
    return 34;
`endif
  endfunction

  // Reference division from the language operators plus the RISC-V special rules.
  function automatic logic [63:0] ref_div(input logic [31:0] av, bv, input logic s);
    logic signed [31:0] sa, sb, sq, sr;
    if (bv == 32'h0) return {32'hFFFF_FFFF, av};
    if (s && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    if (!s) return {av / bv, av % bv};
    sa = av;
    sb = bv;
    sq = sa / sb;
    sr = sa % sb;
    return {sq, sr};
  endfunction

  // Drives one accept cycle; returns in cycle T+1.
  task automatic applyStimulus(input logic [31:0] av, bv, input logic s,
                               input logic [31:0] eq, er);
    a = av;
    b = bv;
    is_signed = s;
    start = 1'b1;
    exp_q.push_back({eq, er});
    tick;
    start = 1'b0;
  endtask

  // Waits for done starting at cycle offset start_n from accept; returns in the done cycle.
  task automatic checkOutput(input string tag, input int start_n, input int exp_lat);
    int          n;
    int          busy_cnt;
    int          exp_busy;
    logic [63:0] e;
    n        = start_n;
    busy_cnt = 0;
    while (!done && n < 200) begin
      busy_cnt += int'(busy);
      tick;
      n++;
    end
    exp_busy = (exp_lat == 1) ? 0 : exp_lat - start_n;
    check({tag, "/done"}, 32'(done), 32'd1);
    check({tag, "/latency"}, n, exp_lat);
    check({tag, "/busy_cycles"}, busy_cnt, exp_busy);
    check({tag, "/busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "/pending"}, exp_q.size(), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "/quot"}, quot, e[63:32]);
      check({tag, "/rem"}, rem, e[31:0]);
    end
  endtask

  task automatic check_pulse_end(input string tag, input logic [31:0] eq, er);
    tick;
    check({tag, "/done_drop"}, 32'(done), 32'd0);
    check({tag, "/quot_hold"}, quot, eq);
    check({tag, "/rem_hold"}, rem, er);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    logic [63:0] r;
    int          extra_done;

    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    is_signed = 1'b0;
    tick;
    tick;
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/quot", quot, 32'd0);
    check("reset/rem", rem, 32'd0);
    reset = 1'b0;
    tick;

    applyStimulus(32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    checkOutput("udiv", 1, 34);
    check_pulse_end("udiv", 32'd14, 32'd2);

    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    checkOutput("sdiv_neg_a", 1, 34);
    applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
    checkOutput("sdiv_neg_b", 1, 34);

    applyStimulus(32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5);
    checkOutput("sdiv0", 1, exp_latency(32'd5, 32'd0, 1'b1));
    check_pulse_end("sdiv0", 32'hFFFF_FFFF, 32'd5);
    applyStimulus(32'hFFFF_FFF0, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF0);
    checkOutput("udiv0", 1, exp_latency(32'hFFFF_FFF0, 32'd0, 1'b0));

    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
    checkOutput("overflow", 1, exp_latency(32'h8000_0000, 32'hFFFF_FFFF, 1'b1));
    check_pulse_end("overflow", 32'h8000_0000, 32'd0);

    // A start during busy must be dropped; a start in the done cycle must be taken.
    applyStimulus(32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    repeat (9) tick;
    a = 32'd9;
    b = 32'd3;
    start = 1'b1;
    tick;
    start = 1'b0;
    checkOutput("ignored_start", 11, 34);
    applyStimulus(32'd9, 32'd3, 1'b0, 32'd3, 32'd0);
    checkOutput("back_to_back", 1, 34);
    check_pulse_end("back_to_back", 32'd3, 32'd0);

    applyStimulus(32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    repeat (14) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("midreset/busy", 32'(busy), 32'd0);
    check("midreset/done", 32'(done), 32'd0);
    check("midreset/quot", quot, 32'd0);
    check("midreset/rem", rem, 32'd0);
    void'(exp_q.pop_back());
    extra_done = 0;
    repeat (40) begin
      extra_done += int'(done);
      tick;
    end
    check("midreset/no_done", extra_done, 32'd0);
    applyStimulus(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0);
    checkOutput("after_reset", 1, 34);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom_range(1, 1000) : $urandom;
      rs = 1'($urandom_range(0, 1));
      r  = ref_div(ra, rb, rs);
      applyStimulus(ra, rb, rs, r[63:32], r[31:0]);
      checkOutput("random", 1, exp_latency(ra, rb, rs));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/melon_div.md
# melon_div

Iterative 32-bit integer divider for the MelonSoc RV32M execute stage, and the counterpart of the pipelined DSP multiplier. It accepts a dividend/divisor pair with a signed/unsigned flag and, after a fixed multi-cycle latency, returns quotient and remainder together with a one-cycle `done` pulse. Divide-by-zero and signed overflow follow RISC-V M-extension rules. The core selects quotient (DIV/DIVU) or remainder (REM/REMU) from the outputs.

## Interface
- `WIDTH`, 32: operand and result width. Only 32 is supported.
- `clk`  input  1  clock; all logic is on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request; accepted only in a cycle where `busy`=0.
- `a`  input  32  dividend; sampled in the accept cycle.
- `b`  input  32  divisor; sampled in the accept cycle.
- `is_signed`  input  1  1 means two's-complement operands (DIV/REM), 0 means unsigned; sampled in the accept cycle.
- `busy`  output  1  a division is in progress.
- `done`  output  1  one-cycle pulse; `quot` and `rem` are valid in this cycle.
- `quot`  output  32  quotient; held until the next completion.
- `rem`  output  32  remainder; held until the next completion.

## Operation
- States are IDLE, RUN and FIX.
- IDLE with `start`=1 (accept):
  - Capture the magnitudes `|a|` and `|b|`. Magnitudes apply only when `is_signed`=1; `|0x80000000|` = 0x80000000 unsigned.
  - Capture `neg_q` = sign(a) XOR sign(b), `neg_r` = sign(a), `div0` = (b==0) and the original `a`.
  - Clear the 32-bit partial remainder and set the counter to 0. Go to RUN.
- RUN performs one restoring step per cycle:
  - Shift {partial remainder, dividend} left by 1.
  - If the 33-bit trial subtract of the divisor from the remainder is not negative, keep the difference and shift in a quotient bit of 1; otherwise shift in 0.
  - After the step with counter = 31, go to FIX.
- FIX:
  - Normal case: `quot` = neg_q ? −Q : Q, `rem` = neg_r ? −R : R.
  - If `div0`: `quot` = 0xFFFFFFFF and `rem` = the original `a`, whatever `is_signed` is.
  - Signed overflow (0x80000000 / −1) comes out of the datapath naturally as `quot` = 0x80000000, `rem` = 0. No special case is needed.
  - FIX pulses `done` and returns to IDLE.
- Handshake:
  - `start` while `busy`=1 is ignored: no queueing and no effect on the running operation.
  - `start` in the `done` cycle is accepted, because the block is already IDLE there.
- Reset, including in the middle of an operation: state = IDLE, `busy`=0, `done`=0, `quot`=0, `rem`=0, counter = 0. An operation aborted by reset never produces `done`.

## Timing
- Cycle numbering: `start` is accepted in cycle T.
- `busy` is 1 in cycles T+1 through T+33: 32 RUN cycles and 1 FIX cycle.
- `done`=1 in cycle T+34 only, and `busy`=0 in that cycle.
- Latency from accept to `done` is 34 cycles. Throughput is one division per 34 cycles with back-to-back starts.
- `quot` and `rem` update only on the edge that raises `done`.

## Configuration
- `MELON_DIV_FAST_SPECIAL_EN` defined:
  - An accepted request with b==0 skips RUN and FIX.
  - It also applies to a signed request with a==0x80000000 and b==0xFFFFFFFF.
  - On the accept edge, `quot` and `rem` are written with the rule values above and `done`=1 in cycle T+1. `busy` stays 0 throughout.
- Macro undefined: every request, including the special cases, takes the full 34-cycle path.
- Result values are identical in both builds; only latency differs.

## Test plan
- Unsigned a=100, b=7 -> `quot`=14, `rem`=2. `done` in exactly cycle T+34, and `busy` high for exactly 33 cycles.
- Signed a=−7 (0xFFFFFFF9), b=2 -> `quot`=0xFFFFFFFD, `rem`=0xFFFFFFFF. Signed a=7, b=−2 -> `quot`=0xFFFFFFFD, `rem`=1.
- Signed a=5, b=0 -> `quot`=0xFFFFFFFF, `rem`=5. Unsigned a=0xFFFFFFF0, b=0 -> `quot`=0xFFFFFFFF, `rem`=0xFFFFFFF0. `done` at T+1 with the macro and at T+34 without.
- Signed a=0x80000000, b=0xFFFFFFFF -> `quot`=0x80000000, `rem`=0, with latency per the macro.
- Back-to-back and ignored starts:
  - Start 100/7, pulse `start` with 9/3 at T+10 -> the second request is ignored; only one `done`, and its results are 14/2.
  - Start 9/3 in the `done` cycle -> second `done` 34 cycles later, `quot`=3, `rem`=0.
- Assert `reset` at T+15 of a running divide -> `busy`=0, `done`=0, `quot`=`rem`=0 the next cycle. No `done` follows, and a new start then completes correctly.
